// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing, derived totals and shared pixel/tap types.
package vga_timing_pkg;

  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BACK   = 48;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FRONT  = 16;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BACK   = 33;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FRONT  = 10;

  // Period of one line (clocks) or one frame (lines) from its four regions.
  function automatic int unsigned region_total(input int unsigned sync_w,
                                               input int unsigned back_w,
                                               input int unsigned active_w,
                                               input int unsigned front_w);
    return sync_w + back_w + active_w + front_w;
  endfunction

  localparam int unsigned DEF_H_TOTAL =
    region_total(DEF_H_SYNC, DEF_H_BACK, DEF_H_ACTIVE, DEF_H_FRONT);
  localparam int unsigned DEF_V_TOTAL =
    region_total(DEF_V_SYNC, DEF_V_BACK, DEF_V_ACTIVE, DEF_V_FRONT);

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Raster flags that travel alongside the memory read.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    logic first;
  } scan_tap_t;

endpackage

// File: rtl/sync_delay.sv
// DEPTH x WIDTH shift register with async active-low clear; DEPTH=0 is a wire.
module sync_delay #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_shift
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per clock; clear to all-zero (inactive) on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
        stage[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_scan.sv
// Raster timing generator and frame-memory scan reader with sync/pixel realignment.
module vga_scan
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BACK   = DEF_H_BACK,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FRONT  = DEF_H_FRONT,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FRONT  = DEF_V_FRONT,
  parameter int unsigned RD_LAT   = 0
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [9:0]  h_addr,
  output logic [9:0]  v_addr,
  output logic        rd_en,
  input  logic [23:0] vga_data,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = region_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int unsigned V_TOTAL = region_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_BEG  = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] V_ACT_BEG  = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] H_ACT_END  = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_ACT_END  = 10'(V_SYNC + V_BACK + V_ACTIVE);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_act;
  logic       v_act;
  scan_tap_t  tap0;
  scan_tap_t  tap_d;
  rgb_t       pix;

  // Free-running raster position; v advances on each h wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Stage 0: region decode and memory address, straight from the counters.
  always_comb begin
    h_act      = (h_cnt >= H_ACT_BEG) && (h_cnt < H_ACT_END);
    v_act      = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
    tap0.act   = h_act && v_act;
    tap0.hs    = h_cnt < H_SYNC_END;
    tap0.vs    = v_cnt < V_SYNC_END;
    tap0.first = (h_cnt == H_ACT_BEG) && (v_cnt == V_ACT_BEG);
    rd_en      = tap0.act;
    h_addr     = tap0.act ? h_cnt - H_ACT_BEG : '0;
    v_addr     = tap0.act ? v_cnt - V_ACT_BEG : '0;
  end

  // Combinational memory needs no realignment, so the delay line is only built
  // when the read takes clocks; sync_delay itself still accepts DEPTH=0.
  if (RD_LAT == 0) begin : g_no_delay
    assign tap_d = tap0;
  end else begin : g_delay
    sync_delay #(
      .DEPTH(RD_LAT),
      .WIDTH($bits(scan_tap_t))
    ) u_delay (
      .clk  (clk),
      .rst_n(resetn),
      .d    (tap0),
      .q    (tap_d)
    );
  end

  // Pin registers: sample returned pixel with its aligned flags; blank forces black.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      valid       <= 1'b0;
      pix         <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ~tap_d.hs;
      vsync       <= ~tap_d.vs;
      valid       <= tap_d.act;
      pix         <= tap_d.act ? rgb_t'(vga_data) : '0;
      frame_start <= tap_d.act & tap_d.first;
    end
  end

  assign vga_r = pix.r;
  assign vga_g = pix.g;
  assign vga_b = pix.b;

endmodule

// File: tb/tb_vga_scan.sv
// Scaled-down raster bench: RD_LAT=0 and RD_LAT=2 instances against a position model.
module tb_vga_scan;

  localparam int unsigned HS = 4, HB = 3, HA = 8, HF = 3;
  localparam int unsigned VS = 2, VB = 3, VA = 4, VF = 2;
  localparam int unsigned HT = HS + HB + HA + HF;   // 18 clocks per line
  localparam int unsigned VT = VS + VB + VA + VF;   // 11 lines per frame
  localparam int unsigned FRAME = HT * VT;          // 198 clocks per frame
  localparam int unsigned HST = HS + HB;
  localparam int unsigned VST = VS + VB;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] mem [VA][HA];

  logic [9:0]  h_addr0, v_addr0, h_addr2, v_addr2;
  logic        rd_en0, rd_en2;
  logic [23:0] data0, data2;
  logic        hsync0, vsync0, valid0, fs0;
  logic        hsync2, vsync2, valid2, fs2;
  logic [7:0]  r0, g0, b0, r2, g2, b2;
  logic [23:0] rq1 = '0, rq2 = '0;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned k = 0;   // rising edges counted since reset was released

  function automatic logic [23:0] mem_rd(input logic [9:0] v, input logic [9:0] h);
    if (v < VA && h < HA) return mem[v][h];
    return 24'hC3C3C3;
  endfunction

  // RD_LAT=0: combinational memory. RD_LAT=2: two registered read stages.
  assign data0 = mem_rd(v_addr0, h_addr0);
  always @(posedge clk) begin
    rq1 <= mem_rd(v_addr2, h_addr2);
    rq2 <= rq1;
  end
  assign data2 = rq2;

  vga_scan #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .RD_LAT(0)
  ) dut0 (
    .clk(clk), .resetn(resetn), .h_addr(h_addr0), .v_addr(v_addr0), .rd_en(rd_en0),
    .vga_data(data0), .hsync(hsync0), .vsync(vsync0), .valid(valid0),
    .vga_r(r0), .vga_g(g0), .vga_b(b0), .frame_start(fs0)
  );

  vga_scan #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .RD_LAT(2)
  ) dut2 (
    .clk(clk), .resetn(resetn), .h_addr(h_addr2), .v_addr(v_addr2), .rd_en(rd_en2),
    .vga_data(data2), .hsync(hsync2), .vsync(vsync2), .valid(valid2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2), .frame_start(fs2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic logic in_window(input int unsigned h, input int unsigned v);
    return (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
  endfunction

  // Expected pins after kk edges for a pipeline of total latency lat.
  // Packing: {pad, hsync, vsync, valid, rgb, frame_start, h_addr, v_addr, rd_en}.
  function automatic logic [63:0] exp_pins(input int unsigned kk, input int unsigned lat);
    int unsigned idx, h, v;
    logic hs, vs, va, fs, re;
    logic [23:0] px;
    logic [9:0] ha, vaa;
    idx = kk % FRAME;
    h = idx % HT;
    v = idx / HT;
    re  = in_window(h, v);
    ha  = re ? 10'(h - HST) : 10'd0;
    vaa = re ? 10'(v - VST) : 10'd0;
    if (kk < lat) begin
      hs = 1'b1; vs = 1'b1; va = 1'b0; px = '0; fs = 1'b0;
    end else begin
      idx = (kk - lat) % FRAME;
      h = idx % HT;
      v = idx / HT;
      va = in_window(h, v);
      hs = !(h < HS);
      vs = !(v < VS);
      px = va ? mem[v - VST][h - HST] : 24'h0;
      fs = va && (h == HST) && (v == VST);
    end
    return {15'd0, hs, vs, va, px, fs, ha, vaa, re};
  endfunction

  function automatic logic [63:0] pins0();
    return {15'd0, hsync0, vsync0, valid0, r0, g0, b0, fs0, h_addr0, v_addr0, rd_en0};
  endfunction

  function automatic logic [63:0] pins2();
    return {15'd0, hsync2, vsync2, valid2, r2, g2, b2, fs2, h_addr2, v_addr2, rd_en2};
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) k <= 0;
    else         k <= k + 1;
  end

  // Every cycle: both instances against the model, and RD_LAT=2 pins against
  // the RD_LAT=0 pins from two cycles earlier.
  logic [27:0] p1, p2;
  always @(negedge clk) begin
    logic [27:0] cur0, cur2;
    check_eq("pins_lat0", pins0(), exp_pins(k, 1));
    check_eq("pins_lat2", pins2(), exp_pins(k, 3));
    cur0 = {hsync0, vsync0, valid0, r0, g0, b0, fs0};
    cur2 = {hsync2, vsync2, valid2, r2, g2, b2, fs2};
    if (k >= 2) check_eq("shift2", 64'(cur2), 64'(p2));
    p2 = p1;
    p1 = cur0;
  end

  initial begin
    int unsigned hs_low, vs_low, val_n, fs_n, wait_n;
    int unsigned fs_k [3];
    logic found;

    for (int unsigned v = 0; v < VA; v++)
      for (int unsigned h = 0; h < HA; h++)
        mem[v][h] = 24'($urandom()) | 24'h1;

    // Reset held: continuous checks expect idle pins throughout.
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;

    // Three full frames measured on the RD_LAT=0 pins.
    hs_low = 0; vs_low = 0; val_n = 0; fs_n = 0;
    for (int unsigned i = 0; i < 3; i++) fs_k[i] = 0;
    for (int unsigned i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (!hsync0) hs_low++;
      if (!vsync0) vs_low++;
      if (valid0)  val_n++;
      if (fs0) begin
        if (fs_n < 3) fs_k[fs_n] = k;
        fs_n++;
      end
    end
    check_eq("hsync_low_clks", 64'(hs_low), 64'(3 * VT * HS));
    check_eq("vsync_low_clks", 64'(vs_low), 64'(3 * VS * HT));
    check_eq("valid_clks",     64'(val_n),  64'(3 * HA * VA));
    check_eq("frame_starts",   64'(fs_n),   64'd3);
    check_eq("first_fs_at",    64'(fs_k[0]), 64'(VST * HT + HST + 1));
    check_eq("fs_spacing_a",   64'(fs_k[1] - fs_k[0]), 64'(FRAME));
    check_eq("fs_spacing_b",   64'(fs_k[2] - fs_k[1]), 64'(FRAME));

    // Random mid-frame async reset pulses spanning one rising edge.
    for (int unsigned n = 0; n < 4; n++) begin
      repeat ($urandom_range(1, 2 * FRAME)) @(negedge clk);
      @(posedge clk);
      #3 resetn = 1'b0;
      #1;
      check_eq("async_rst_lat0", pins0(), exp_pins(0, 1));
      check_eq("async_rst_lat2", pins2(), exp_pins(0, 3));
      @(posedge clk);
      #3 resetn = 1'b1;
      found = 1'b0;
      wait_n = 0;
      while (!found && wait_n < 2 * FRAME) begin
        @(negedge clk);
        wait_n++;
        if (fs0) found = 1'b1;
      end
      check_eq("fs_after_rst", found ? 64'(k) : 64'hFFFF, 64'(VST * HT + HST + 1));
    end

    repeat (20) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
